// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and widths for the pipeline stall/flush controller.
// Also holds the single-source register-match rule used by hazard detection.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 32;
    localparam int FLUSH_CNT_W = 16;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_BUSY = 1'b1
    } state_t;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic reg_match(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dest,
        input logic                  dest_valid
    );
        return dest_valid && (dest != '0) && (src == dest);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// RAW hazard detection for the ID-stage instruction against EXE and MEM.
// Purely combinational; the forwarding mode selects which producers can stall.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic                  fwd_en,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] idexe_dest,
    input  logic                  idexe_wb_en,
    input  logic                  idexe_mem_read,
    input  logic [REG_ADDR_W-1:0] exemem_dest,
    input  logic                  exemem_wb_en,
    output logic                  hazard
);

    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [1:0]            src_used;
    logic [1:0]            src_hit;

    assign src_addr[0] = id_src1;
    assign src_addr[1] = id_src2;
    assign src_used    = {id_two_src, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic exe_hit;
            logic mem_hit;

            // With forwarding only a load in EXE is too late to forward from.
            assign exe_hit = fwd_en ? reg_match(src_addr[gi], idexe_dest, idexe_wb_en && idexe_mem_read)
                                    : reg_match(src_addr[gi], idexe_dest, idexe_wb_en);
            assign mem_hit = !fwd_en && reg_match(src_addr[gi], exemem_dest, exemem_wb_en);
            assign src_hit[gi] = src_used[gi] && (exe_hit || mem_hit);
        end
    endgenerate

    assign hazard = |src_hit;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: SRAM handshake FSM, freeze/branch/hazard
// priority for the stage register enables, perf counters and timeout flag.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fwd_en,
    input  logic [REG_ADDR_W-1:0]  id_src1,
    input  logic [REG_ADDR_W-1:0]  id_src2,
    input  logic                   id_two_src,
    input  logic [REG_ADDR_W-1:0]  idexe_dest,
    input  logic                   idexe_wb_en,
    input  logic                   idexe_mem_read,
    input  logic [REG_ADDR_W-1:0]  exemem_dest,
    input  logic                   exemem_wb_en,
    input  logic                   mem_access,
    input  logic                   exe_branch_taken,
    input  logic                   sram_ready,
    output logic                   sram_req,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idexe_en,
    output logic                   exemem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idexe_flush,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [FLUSH_CNT_W-1:0] flush_count,
    output logic                   mem_error
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t                  state_reg;
    state_t                  state_next;
    logic [WAIT_W-1:0]       wait_cnt_reg;
    logic [WAIT_W-1:0]       wait_cnt_next;
    logic [STALL_CNT_W-1:0]  stall_cycles_reg;
    logic [FLUSH_CNT_W-1:0]  flush_count_reg;
    logic                    mem_error_reg;
    logic                    hazard;
    logic                    freeze;
    logic                    flush_apply;

    hazard_detect u_hazard_detect (
        .fwd_en         (fwd_en),
        .id_src1        (id_src1),
        .id_src2        (id_src2),
        .id_two_src     (id_two_src),
        .idexe_dest     (idexe_dest),
        .idexe_wb_en    (idexe_wb_en),
        .idexe_mem_read (idexe_mem_read),
        .exemem_dest    (exemem_dest),
        .exemem_wb_en   (exemem_wb_en),
        .hazard         (hazard)
    );

    always_comb begin
        state_next  = state_reg;
        sram_req    = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idexe_en    = 1'b1;
        exemem_en   = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;
        flush_apply = 1'b0;

        case (state_reg)
            RUN: begin
                sram_req = mem_access;
                if (mem_access && !sram_ready) state_next = MEM_BUSY;
            end
            MEM_BUSY: begin
                sram_req = 1'b1;
                if (sram_ready) state_next = RUN;
            end
            default: state_next = RUN;
        endcase

        // Reset aborts any access and lets every stage register take its own reset.
        if (reset) sram_req = 1'b0;
        freeze = sram_req && !sram_ready;

        if (reset) begin
            state_next = RUN;
        end else if (freeze) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idexe_en  = 1'b0;
            exemem_en = 1'b0;
            memwb_en  = 1'b0;
        end else if (exe_branch_taken) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            flush_apply = 1'b1;
        end else if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idexe_flush = 1'b1;
        end
    end

    // Wait counter restarts on MEM_BUSY entry and saturates at the timeout.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_reg == MEM_BUSY) begin
            if (wait_cnt_reg != WAIT_W'(MEM_TIMEOUT)) wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end else if (state_next == MEM_BUSY) begin
            wait_cnt_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= RUN;
            wait_cnt_reg     <= '0;
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
            mem_error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (!pc_en && stall_cycles_reg != '1)
                stall_cycles_reg <= stall_cycles_reg + STALL_CNT_W'(1);
            if (flush_apply && flush_count_reg != '1)
                flush_count_reg <= flush_count_reg + FLUSH_CNT_W'(1);
            if (state_reg == MEM_BUSY && wait_cnt_next == WAIT_W'(MEM_TIMEOUT))
                mem_error_reg <= 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
    assign mem_error    = mem_error_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl with a queue-based scoreboard.
// The stimulus side predicts each cycle's outputs; a negedge monitor compares.
module tb_pipeline_ctrl;

    localparam int T_OUT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        fwd_en;
    logic [4:0]  id_src1, id_src2, idexe_dest, exemem_dest;
    logic        id_two_src, idexe_wb_en, idexe_mem_read, exemem_wb_en;
    logic        mem_access, exe_branch_taken, sram_ready;
    logic        sram_req, pc_en, ifid_en, idexe_en, exemem_en, memwb_en;
    logic        ifid_flush, idexe_flush, mem_error;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    pipeline_ctrl #(.MEM_TIMEOUT(T_OUT)) dut (
        .clock            (clock),
        .reset            (reset),
        .fwd_en           (fwd_en),
        .id_src1          (id_src1),
        .id_src2          (id_src2),
        .id_two_src       (id_two_src),
        .idexe_dest       (idexe_dest),
        .idexe_wb_en      (idexe_wb_en),
        .idexe_mem_read   (idexe_mem_read),
        .exemem_dest      (exemem_dest),
        .exemem_wb_en     (exemem_wb_en),
        .mem_access       (mem_access),
        .exe_branch_taken (exe_branch_taken),
        .sram_ready       (sram_ready),
        .sram_req         (sram_req),
        .pc_en            (pc_en),
        .ifid_en          (ifid_en),
        .idexe_en         (idexe_en),
        .exemem_en        (exemem_en),
        .memwb_en         (memwb_en),
        .ifid_flush       (ifid_flush),
        .idexe_flush      (idexe_flush),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count),
        .mem_error        (mem_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [4:0]  en;      // pc, ifid, idexe, exemem, memwb
        logic [1:0]  flush;   // ifid, idexe
        logic        req;
        logic        err;
        int unsigned stalls;
        int unsigned flushes;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference state, kept as plain booleans/integers.
    bit          m_waiting;
    int          m_wait;
    bit          m_err;
    int unsigned m_stalls, m_flushes;

    function automatic bit raw_on(input logic [4:0] src);
        if (src == 0) return 0;
        if (fwd_en) return idexe_wb_en && idexe_mem_read && src == idexe_dest;
        return (idexe_wb_en && src == idexe_dest) || (exemem_wb_en && src == exemem_dest);
    endfunction

    task automatic step();
        exp_t e;
        bit req, frz, haz, stall_now;
        haz = raw_on(id_src1) || (id_two_src && raw_on(id_src2));
        req = !reset && (m_waiting || mem_access);
        frz = req && !sram_ready;
        e.cyc = cyc; e.req = req; e.err = m_err;
        e.stalls = m_stalls; e.flushes = m_flushes;
        e.en = 5'b11111; e.flush = 2'b00;
        if (!reset) begin
            if (frz)                   e.en = 5'b00000;
            else if (exe_branch_taken) e.flush = 2'b11;
            else if (haz) begin        e.en = 5'b00111; e.flush = 2'b01; end
        end
        exp_q.push_back(e);
        stall_now = (e.en[4] == 1'b0);
        if (reset) begin
            m_waiting = 0; m_wait = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (m_waiting) begin
                m_wait++;
                if (m_wait >= T_OUT) m_err = 1;
            end else if (frz) begin
                m_wait = 0;
            end
            m_waiting = frz;
            if (stall_now && m_stalls != 32'hFFFF_FFFF) m_stalls++;
            if (e.flush == 2'b11 && m_flushes != 16'hFFFF) m_flushes++;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int c, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("enables", e.cyc, {pc_en, ifid_en, idexe_en, exemem_en, memwb_en}, e.en);
            chk("flushes", e.cyc, {ifid_flush, idexe_flush}, e.flush);
            chk("sram_req", e.cyc, sram_req, e.req);
            chk("mem_error", e.cyc, mem_error, e.err);
            chk("stall_cycles", e.cyc, stall_cycles, e.stalls);
            chk("flush_count", e.cyc, flush_count, e.flushes[15:0]);
            $display("cyc %0d en=%b fl=%b req=%b err=%b stalls=%0d flushes=%0d",
                     e.cyc, e.en, e.flush, e.req, e.err, e.stalls, e.flushes);
        end
    end

    task automatic idle();
        reset = 0; fwd_en = 1; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        idexe_dest = 0; idexe_wb_en = 0; idexe_mem_read = 0;
        exemem_dest = 0; exemem_wb_en = 0;
        mem_access = 0; exe_branch_taken = 0; sram_ready = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clock); #1;          // initial reset, not scored
        reset = 0;
        m_waiting = 0; m_wait = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        step(); step();

        // Load-use, then the bubbled instruction leaves EXE
        idexe_mem_read = 1; idexe_wb_en = 1; idexe_dest = 3; id_src1 = 3;
        step();
        idexe_mem_read = 0; idexe_wb_en = 0; idexe_dest = 0;
        step();
        // Zero register never matches
        idexe_mem_read = 1; idexe_wb_en = 1; idexe_dest = 0; id_src1 = 0;
        step();
        idle();
        // No forwarding: second source against MEM stage
        fwd_en = 0; exemem_dest = 5; exemem_wb_en = 1; id_two_src = 1; id_src2 = 5;
        step();
        id_two_src = 0;
        step();
        idle();
        // 4-cycle SRAM access
        mem_access = 1;
        step(); step(); step();
        sram_ready = 1;
        step();
        idle();
        step();
        // Single-cycle access
        mem_access = 1; sram_ready = 1;
        step();
        idle();
        // Branch beats hazard
        exe_branch_taken = 1; idexe_mem_read = 1; idexe_wb_en = 1; idexe_dest = 7; id_src1 = 7;
        step();
        idle();
        // Branch during freeze is held until ready
        exe_branch_taken = 1; mem_access = 1;
        step(); step();
        sram_ready = 1;
        step();
        idle();
        // Timeout, then a 1-cycle reset mid-access
        mem_access = 1;
        repeat (7) step();
        reset = 1;
        step();
        reset = 0;
        step();
        idle();
        step();

        for (int i = 0; i < 1500; i++) begin
            reset            = ($urandom_range(0, 149) == 0);
            fwd_en           = $urandom_range(0, 1);
            id_src1          = 5'($urandom_range(0, 3));
            id_src2          = 5'($urandom_range(0, 3));
            id_two_src       = $urandom_range(0, 1);
            idexe_dest       = 5'($urandom_range(0, 3));
            idexe_wb_en      = $urandom_range(0, 1);
            idexe_mem_read   = $urandom_range(0, 1);
            exemem_dest      = 5'($urandom_range(0, 3));
            exemem_wb_en     = $urandom_range(0, 1);
            mem_access       = ($urandom_range(0, 3) == 0);
            exe_branch_taken = ($urandom_range(0, 5) == 0);
            sram_ready       = ($urandom_range(0, 9) < 3);
            step();
        end
        idle();

        repeat (2) @(negedge clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
